zapper_shot_ctrl: RTL and testbench

Sequences one light-gun shot for the Duck Hunt datapath. Debounces the raw Zapper trigger, then commands the VGA renderer through one black frame and one target frame, and qualifies the photodiode `detect` line in each frame. It posts a hit/miss result that the CR16 reads through its I/O port and acknowledges. It sits between the Zapper pins, the VGA timing block (`vsync_pulse`) and the processor I/O decode.

---
 rtl/zapper_pkg.sv | 41 ++++
 rtl/zapper_shot_ctrl_sync2.sv | 24 ++
 rtl/zapper_shot_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_zapper_shot_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zapper_pkg.sv
// Shared definitions for the Zapper light-gun shot controller:
// FSM states, default timing constants and the CR16 status-port layout.
package zapper_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        WAIT_FRAME,
        BLACK,
        TARGET,
        REPORT,
        HOLDOFF
    } shot_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int HIT_MIN_DEF         = 16;
    localparam int FRAME_TIMEOUT_DEF   = 2000000;

    // Bit positions of the status word read by the CR16 I/O decode.
    localparam int IO_VALID_BIT  = 0;
    localparam int IO_HIT_BIT    = 1;
    localparam int IO_BUSY_BIT   = 2;
    localparam int IO_COUNT_LSB  = 8;
    localparam int IO_COUNT_MSB  = 15;

    function automatic logic [15:0] io_status_word(
        input logic       valid,
        input logic       hit,
        input logic       busy,
        input logic [7:0] count
    );
        logic [15:0] word;
        word                             = '0;
        word[IO_VALID_BIT]               = valid;
        word[IO_HIT_BIT]                 = hit;
        word[IO_BUSY_BIT]                = busy;
        word[IO_COUNT_MSB:IO_COUNT_LSB]  = count;
        return word;
    endfunction

endpackage

// File: rtl/zapper_shot_ctrl_sync2.sv
// Two-flop synchronizer bringing an asynchronous Zapper pin into the clk domain.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/zapper_shot_ctrl.sv
// Light-gun shot sequencer: debounces the trigger, flashes a black then a target
// frame, qualifies the photodiode and posts a hit/miss result for the CR16.
module zapper_shot_ctrl
    import zapper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HIT_MIN         = HIT_MIN_DEF,
    parameter int FRAME_TIMEOUT   = FRAME_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic       detect,
    input  logic       vsync_pulse,
    input  logic       result_ack,
    output logic       flash_black,
    output logic       flash_target,
    output logic       busy,
    output logic       result_valid,
    output logic       hit,
    output logic [7:0] shot_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HIT_MIN + 1);
    localparam int TW = $clog2(FRAME_TIMEOUT + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HIT_SAT  = HW'(HIT_MIN);
    localparam logic [TW-1:0] TO_LAST  = TW'(FRAME_TIMEOUT - 1);

    logic trig_s;
    logic det_s;

    sync2 u_sync_trig (.clk(clk), .reset(reset), .d(trigger), .q(trig_s));
    sync2 u_sync_det  (.clk(clk), .reset(reset), .d(detect),  .q(det_s));

    shot_state_t   state_q, state_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [HW-1:0] det_cnt_q, det_cnt_d;
    logic          cheat_q, cheat_d;
    logic          timed_out_q, timed_out_d;
    logic          flash_black_q, flash_black_d;
    logic          flash_target_q, flash_target_d;
    logic          busy_q, busy_d;
    logic          result_valid_q, result_valid_d;
    logic          hit_q, hit_d;
    logic [7:0]    shot_count_q, shot_count_d;

    always_comb begin
        state_d        = state_q;
        deb_cnt_d      = deb_cnt_q;
        to_cnt_d       = to_cnt_q;
        det_cnt_d      = det_cnt_q;
        cheat_d        = cheat_q;
        timed_out_d    = timed_out_q;
        hit_d          = hit_q;
        shot_count_d   = shot_count_q;
        result_valid_d = result_valid_q;

        if (result_ack) begin
            result_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                deb_cnt_d = '0;
                if (trig_s) begin
                    state_d   = DEBOUNCE;
                    deb_cnt_d = DW'(1);
                end
            end
            DEBOUNCE: begin
                if (!trig_s) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q >= DEB_LAST) begin
                    state_d   = WAIT_FRAME;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
            WAIT_FRAME: begin
                if (vsync_pulse) begin
                    state_d   = BLACK;
                    cheat_d   = 1'b0;
                    det_cnt_d = '0;
                end
            end
            BLACK: begin
                cheat_d = cheat_q | det_s;
                if (vsync_pulse) begin
                    state_d = TARGET;
                end
            end
            TARGET: begin
                if (det_s && (det_cnt_q < HIT_SAT)) begin
                    det_cnt_d = det_cnt_q + HW'(1);
                end
                if (vsync_pulse) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                // A report here always wins over a coincident acknowledge.
                hit_d          = !timed_out_q && !cheat_q && (det_cnt_q >= HIT_SAT);
                result_valid_d = 1'b1;
                shot_count_d   = shot_count_q + 8'd1;
                timed_out_d    = 1'b0;
                state_d        = HOLDOFF;
            end
            HOLDOFF: begin
                if (!trig_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Missing frames abort the shot as a miss rather than hanging the game.
        if (state_q inside {WAIT_FRAME, BLACK, TARGET}) begin
            if (vsync_pulse) begin
                to_cnt_d = '0;
            end else if (to_cnt_q >= TO_LAST) begin
                to_cnt_d    = '0;
                timed_out_d = 1'b1;
                state_d     = REPORT;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end else begin
            to_cnt_d = '0;
        end

        flash_black_d  = (state_d == BLACK);
        flash_target_d = (state_d == TARGET);
        busy_d         = !(state_d inside {IDLE, HOLDOFF});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            deb_cnt_q      <= '0;
            to_cnt_q       <= '0;
            det_cnt_q      <= '0;
            cheat_q        <= 1'b0;
            timed_out_q    <= 1'b0;
            flash_black_q  <= 1'b0;
            flash_target_q <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            hit_q          <= 1'b0;
            shot_count_q   <= 8'd0;
        end else begin
            state_q        <= state_d;
            deb_cnt_q      <= deb_cnt_d;
            to_cnt_q       <= to_cnt_d;
            det_cnt_q      <= det_cnt_d;
            cheat_q        <= cheat_d;
            timed_out_q    <= timed_out_d;
            flash_black_q  <= flash_black_d;
            flash_target_q <= flash_target_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            hit_q          <= hit_d;
            shot_count_q   <= shot_count_d;
        end
    end

    assign flash_black  = flash_black_q;
    assign flash_target = flash_target_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign hit          = hit_q;
    assign shot_count   = shot_count_q;

endmodule

// File: tb/tb_zapper_shot_ctrl.sv
// Directed bench for zapper_shot_ctrl with short debounce/timeout settings
// and a free-running 40-cycle vsync strobe.
module tb_zapper_shot_ctrl;

    localparam int DEB  = 8;
    localparam int HMIN = 4;
    localparam int TOUT = 100;
    localparam int VPER = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       trigger;
    logic       detect;
    logic       vsync_pulse;
    logic       result_ack;
    logic       flash_black;
    logic       flash_target;
    logic       busy;
    logic       result_valid;
    logic       hit;
    logic [7:0] shot_count;

    int errors = 0;
    int checks = 0;
    int phase  = 0;
    bit vsync_en = 1'b1;

    zapper_shot_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .HIT_MIN(HMIN),
        .FRAME_TIMEOUT(TOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .trigger(trigger),
        .detect(detect),
        .vsync_pulse(vsync_pulse),
        .result_ack(result_ack),
        .flash_black(flash_black),
        .flash_target(flash_target),
        .busy(busy),
        .result_valid(result_valid),
        .hit(hit),
        .shot_count(shot_count)
    );

    always #5 clk = ~clk;

    // Vsync changes on the falling edge so it straddles exactly one rising edge.
    initial begin
        vsync_pulse = 1'b0;
        forever begin
            @(negedge clk);
            phase       = (phase == VPER - 1) ? 0 : phase + 1;
            vsync_pulse = vsync_en && (phase == 0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic trig, input logic det, input logic ack);
        trigger    = trig;
        detect     = det;
        result_ack = ack;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_flash_black"},  flash_black,  0);
        checkOutput({tag, "_flash_target"}, flash_target, 0);
        checkOutput({tag, "_busy"},         busy,         0);
        checkOutput({tag, "_result_valid"}, result_valid, 0);
        checkOutput({tag, "_hit"},          hit,          0);
        checkOutput({tag, "_shot_count"},   shot_count,   0);
    endtask

    task automatic waitBlack(input string tag);
        int n;
        n = 0;
        while (flash_black !== 1'b1 && n < 200) begin
            waitCycle();
            n++;
        end
        checkOutput({tag, "_black_rise"}, flash_black, 1);
        checkOutput({tag, "_black_phase"}, phase, 0);
    endtask

    task automatic waitTarget(input string tag);
        int n;
        n = 0;
        while (flash_target !== 1'b1 && n < 60) begin
            waitCycle();
            n++;
        end
        checkOutput({tag, "_target_rise"}, flash_target, 1);
        checkOutput({tag, "_black_fall"}, flash_black, 0);
    endtask

    // Full shot with the trigger held; n_tgt detect-high cycles inside the target frame.
    task automatic runShot(input string tag, input int n_tgt, input logic det_black, input logic ack_at_report);
        int n;
        logic [7:0] exp_cnt;
        exp_cnt = shot_count + 8'd1;
        applyStimulus(1'b1, det_black, 1'b0);
        waitBlack(tag);
        waitTarget(tag);
        repeat (5) waitCycle();
        if (n_tgt > 0) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            repeat (n_tgt) waitCycle();
        end
        applyStimulus(1'b1, det_black, 1'b0);
        n = 0;
        while (flash_target !== 1'b0 && n < 60) begin
            waitCycle();
            n++;
        end
        checkOutput({tag, "_target_fall"}, flash_target, 0);
        checkOutput({tag, "_target_phase"}, phase, 0);
        applyStimulus(1'b1, det_black, ack_at_report);
        waitCycle();
        applyStimulus(1'b1, det_black, 1'b0);
        checkOutput({tag, "_report_phase"}, phase, 1);
        checkOutput({tag, "_shot_count"}, shot_count, exp_cnt);
        checkOutput({tag, "_result_valid"}, result_valid, 1);
        checkOutput({tag, "_busy_holdoff"}, busy, 0);
    endtask

    task automatic releaseTrigger();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (5) waitCycle();
    endtask

    // Starves vsync during the black (or target) frame so the timeout ends the shot.
    task automatic runTimeout(input string tag, input bit in_target);
        int n;
        logic [7:0] exp_cnt;
        exp_cnt = shot_count + 8'd1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitBlack(tag);
        if (in_target) begin
            waitTarget(tag);
        end
        vsync_en = 1'b0;
        n = 0;
        while ((in_target ? flash_target : flash_black) === 1'b1 && n < 300) begin
            n++;
            if (n == 3) applyStimulus(1'b1, 1'b1, 1'b0);
            if (n == 13) applyStimulus(1'b1, 1'b0, 1'b0);
            waitCycle();
        end
        checkOutput({tag, "_frame_len"}, n, TOUT);
        waitCycle();
        checkOutput({tag, "_shot_count"}, shot_count, exp_cnt);
        checkOutput({tag, "_hit"}, hit, 0);
        checkOutput({tag, "_result_valid"}, result_valid, 1);
        checkOutput({tag, "_flash_black"}, flash_black, 0);
        checkOutput({tag, "_flash_target"}, flash_target, 0);
        vsync_en = 1'b1;
        releaseTrigger();
    endtask

    initial begin
        int seen_flash;
        int seen_busy;

        applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) waitCycle();
        checkResetOutputs("reset");
        reset = 1'b0;
        repeat (3) waitCycle();

        // Trigger bounce never completes a debounce window.
        seen_flash = 0;
        seen_busy  = 0;
        for (int i = 0; i < 24; i++) begin
            if (i < 5 || (i >= 7 && i < 12)) applyStimulus(1'b1, 1'b0, 1'b0);
            else applyStimulus(1'b0, 1'b0, 1'b0);
            waitCycle();
            if (flash_black === 1'b1) seen_flash++;
            if (busy === 1'b1) seen_busy++;
        end
        checkOutput("bounce_no_flash", seen_flash, 0);
        checkOutput("bounce_debounce_busy", seen_busy > 0, 1);
        checkOutput("bounce_shot_count", shot_count, 0);
        checkOutput("bounce_idle", busy, 0);

        runShot("clean", 10, 1'b0, 1'b0);
        checkOutput("clean_hit", hit, 1);

        // Held trigger must not re-fire.
        seen_flash = 0;
        for (int i = 0; i < 100; i++) begin
            waitCycle();
            if (flash_black === 1'b1 || busy === 1'b1) seen_flash++;
        end
        checkOutput("holdoff_no_refire", seen_flash, 0);
        checkOutput("holdoff_shot_count", shot_count, 1);
        releaseTrigger();

        applyStimulus(1'b0, 1'b0, 1'b1);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ack_clears_valid", result_valid, 0);
        checkOutput("ack_keeps_hit", hit, 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ack_idle_ignored", result_valid, 0);

        runShot("cheat", 10, 1'b1, 1'b0);
        checkOutput("cheat_hit", hit, 0);
        releaseTrigger();

        runShot("short3", 3, 1'b0, 1'b0);
        checkOutput("short3_hit", hit, 0);
        releaseTrigger();

        runShot("exact4", 4, 1'b0, 1'b0);
        checkOutput("exact4_hit", hit, 1);
        releaseTrigger();

        runTimeout("to_black", 1'b0);
        runShot("rearm", 10, 1'b0, 1'b0);
        checkOutput("rearm_hit", hit, 1);
        releaseTrigger();
        runTimeout("to_target", 1'b1);

        runShot("ack_report", 10, 1'b0, 1'b1);
        checkOutput("ack_report_hit", hit, 1);
        releaseTrigger();

        // Reset in the middle of the target frame.
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitBlack("midreset");
        waitTarget("midreset");
        repeat (3) waitCycle();
        reset = 1'b1;
        waitCycle();
        checkResetOutputs("midreset");
        reset = 1'b0;
        releaseTrigger();
        checkOutput("midreset_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
